// File: rtl/vga_link_tx_pkg.sv
// Shared encodings, frame layout and FSM state type for the VGA serial link transmitter.
package vga_link_tx_pkg;

    localparam logic [1:0] KIND_CHAR     = 2'b00;
    localparam logic [1:0] KIND_ROW      = 2'b01;
    localparam logic [1:0] KIND_COLOUR   = 2'b10;
    localparam logic [1:0] KIND_RSVD     = 2'b11;

    localparam logic [1:0] COLOUR_PREFIX = 2'b10;
    localparam int         CHAR_BITS     = 8;
    localparam int         ROW_BITS      = 6;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        LOW  = 2'd2,
        HIGH = 2'd3
    } state_t;

    // A queued frame: which channel it goes to and the bits to shift (LSB first).
    typedef struct packed {
        logic       is_row;
        logic [7:0] bits;
    } frame_t;

    // Formats a command into the frame it will be transmitted as.
    function automatic frame_t make_frame(input logic [1:0] kind, input logic [7:0] data);
        frame_t f;
        f.is_row = (kind == KIND_ROW);
        f.bits   = (kind == KIND_COLOUR) ? {COLOUR_PREFIX, data[5:0]} : data;
        if (kind == KIND_ROW) begin
            f.bits[7:6] = 2'b00;
        end
        return f;
    endfunction

endpackage

// File: rtl/vga_link_tx_if.sv
// Command handshake and serial link signals of the VGA link transmitter.
// Handshake: a command transfers on a clk25 rising edge where in_valid and
// in_ready are both 1; in_valid may be raised at any time, in_ready does not
// depend on in_valid, and kind/data must be stable while in_valid is high.
interface vga_link_tx_if;
    import vga_link_tx_pkg::*;

    logic       in_valid;
    logic [1:0] in_kind;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wclk;
    logic       d0;
    logic       dc;
    logic       cs;
    logic       busy;
    state_t     fsm_state;

    modport master (
        output in_valid, in_kind, in_data,
        input  in_ready, wclk, d0, dc, cs, busy, fsm_state
    );

    modport slave (
        input  in_valid, in_kind, in_data,
        output in_ready, wclk, d0, dc, cs, busy, fsm_state
    );

endinterface

// File: rtl/vga_link_fifo.sv
// Command FIFO: power-of-two depth, head read straight from storage registers,
// registered full/empty flags.
module vga_link_fifo
    import vga_link_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  frame_t push_data,
    input  logic   pop,
    output frame_t head,
    output logic   full,
    output logic   empty
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    frame_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic            push_ok;
    logic            pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and flags; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/vga_link_tx.sv
// VGA serial link transmitter: queues CHAR/ROW/COLOUR commands and shifts them
// out as wclk-framed pulses, with two ROW-0 sync frames after every reset.
module vga_link_tx
    import vga_link_tx_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DEPTH   = 4
) (
    input logic          clk25,
    input logic          rst,
    vga_link_tx_if.slave link
);
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam frame_t     SYNC_FRAME = '{is_row: 1'b1, bits: 8'h00};

    state_t     state, state_next;
    logic [7:0] div_cnt, div_next;
    logic [3:0] bit_cnt, bit_next;
    logic [3:0] last_idx;
    frame_t     frame, frame_next, load_frame, head, push_frame;
    logic [1:0] sync_left, sync_left_next;
    logic       wclk_q, wclk_next;
    logic [2:0] lines_q, lines_next;   // {cs, dc, d0}
    logic       load, push, pop, full, empty, in_ready;

    // {cs, dc, d0} for pulse idx of frame f; the final pulse is the latch.
    function automatic logic [2:0] pulse_lines(input frame_t f, input logic [3:0] idx);
        logic last;
        last = f.is_row ? (idx == 4'(ROW_BITS)) : (idx == 4'(CHAR_BITS));
        return {~f.is_row, ~last, last ? 1'b0 : f.bits[idx[2:0]]};
    endfunction

    assign in_ready   = !rst && !full && (sync_left == 2'd0);
    assign push       = link.in_valid && in_ready && (link.in_kind != KIND_RSVD);
    assign push_frame = make_frame(link.in_kind, link.in_data);
    assign last_idx   = frame.is_row ? 4'(ROW_BITS) : 4'(CHAR_BITS);

    vga_link_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk25),
        .rst       (rst),
        .push      (push),
        .push_data (push_frame),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Next-state logic: divider phases, bit stepping, frame loading and sync sequencing.
    always_comb begin
        state_next     = state;
        div_next       = div_cnt;
        bit_next       = bit_cnt;
        frame_next     = frame;
        sync_left_next = sync_left;
        wclk_next      = wclk_q;
        lines_next     = lines_q;
        pop            = 1'b0;
        load           = 1'b0;
        load_frame     = head;
        case (state)
            SYNC: begin
                load       = 1'b1;
                load_frame = SYNC_FRAME;
            end
            IDLE: begin
                if (!empty) begin
                    load = 1'b1;
                    pop  = 1'b1;
                end
            end
            LOW: begin
                if (div_cnt == DIV_LAST) begin
                    div_next   = '0;
                    wclk_next  = 1'b1;
                    state_next = HIGH;
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            HIGH: begin
                if (div_cnt == DIV_LAST) begin
                    div_next  = '0;
                    wclk_next = 1'b0;
                    if (bit_cnt != last_idx) begin
                        bit_next   = bit_cnt + 4'd1;
                        state_next = LOW;
                        lines_next = pulse_lines(frame, bit_cnt + 4'd1);
                    end else if (sync_left == 2'd2) begin
                        // First sync frame done: the second one follows without a gap.
                        sync_left_next = 2'd1;
                        load           = 1'b1;
                        load_frame     = SYNC_FRAME;
                    end else begin
                        sync_left_next = 2'd0;
                        if (!empty) begin
                            load = 1'b1;
                            pop  = 1'b1;
                        end else begin
                            state_next = IDLE;
                            lines_next = 3'b000;
                        end
                    end
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        // A frame load drives bit 0 on this same edge and starts the low phase.
        if (load) begin
            state_next = LOW;
            div_next   = '0;
            bit_next   = '0;
            frame_next = load_frame;
            wclk_next  = 1'b0;
            lines_next = pulse_lines(load_frame, 4'd0);
        end
    end

    // State and registered link outputs; reset aborts any frame and re-arms sync.
    always_ff @(posedge clk25) begin
        if (rst) begin
            state     <= SYNC;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            frame     <= '0;
            sync_left <= 2'd2;
            wclk_q    <= 1'b0;
            lines_q   <= 3'b000;
        end else begin
            state     <= state_next;
            div_cnt   <= div_next;
            bit_cnt   <= bit_next;
            frame     <= frame_next;
            sync_left <= sync_left_next;
            wclk_q    <= wclk_next;
            lines_q   <= lines_next;
        end
    end

    assign link.in_ready  = in_ready;
    assign link.wclk      = wclk_q;
    assign link.cs        = lines_q[2];
    assign link.dc        = lines_q[1];
    assign link.d0        = lines_q[0];
    assign link.busy      = rst || (sync_left != 2'd0) || (state != IDLE) || !empty;
    assign link.fsm_state = state;

endmodule

// File: tb/tb_vga_link_tx.sv
// Bench for vga_link_tx: a display receiver model on wclk rising edges plus a
// pulse-level expectation built from each command's kind and payload.
module tb_vga_link_tx;
    import vga_link_tx_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int DEPTH   = 4;
    localparam int PER     = 10;
    localparam int W       = 3;

    logic clk25 = 1'b0;
    logic rst   = 1'b1;

    vga_link_tx_if link ();

    vga_link_tx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk25 (clk25),
        .rst   (rst),
        .link  (link)
    );

    // clock / reset block
    always #(PER / 2) clk25 = ~clk25;

    int checks = 0;
    int passed = 0;

    // scoreboard: expected pulses {cs, dc, d0}; observed pulses and their times
    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_q[$];
    longint       rise_t[$];

    // display receiver model
    logic [7:0] rx_sr = 8'h00;
    logic [7:0] rx_mem [8192];
    int         rx_addr = 0;
    logic [5:0] rx_colour = 6'd0;
    int         rx_writes = 0;

    bit ready_dropped;
    int accepted;
    int acc_at_drop;

    always @(posedge link.wclk) begin
        act_q.push_back({link.cs, link.dc, link.d0});
        rise_t.push_back($time);
        if (link.dc) begin
            rx_sr = {link.d0, rx_sr[7:1]};
        end else if (link.cs) begin
            if (rx_sr[7:6] == 2'b10) begin
                rx_colour = rx_sr[5:0];
            end else begin
                rx_mem[rx_addr] = rx_sr;
                rx_addr = (rx_addr + 1) % 8192;
                rx_writes++;
            end
        end else begin
            rx_addr = int'(rx_sr[7:2]) * 80;
        end
    end

    // Expected pulses for one command.
    function automatic void add_frame(input logic [1:0] k, input logic [7:0] d);
        logic [7:0] b;
        int         nb;
        logic       c;
        if (k == 2'b11) return;
        if (k == 2'b01) begin
            nb = 6; c = 1'b0; b = d;
        end else begin
            nb = 8; c = 1'b1; b = (k == 2'b10) ? {2'b10, d[5:0]} : d;
        end
        for (int i = 0; i < nb; i++) exp_q.push_back({c, 1'b1, b[i]});
        exp_q.push_back({c, 1'b0, 1'b0});
    endfunction

    function automatic int first_diff(input int base);
        int n;
        n = act_q.size() - base;
        if (exp_q.size() < n) n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (act_q[base + i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    // driver: offer a command from a negedge, return at the negedge after acceptance
    task automatic send(input logic [1:0] k, input logic [7:0] d, output longint t_acc, output bit ok);
        int n;
        link.in_valid = 1'b1;
        link.in_kind  = k;
        link.in_data  = d;
        n = 0;
        if (link.in_ready !== 1'b1 && !ready_dropped) begin
            ready_dropped = 1'b1;
            acc_at_drop   = accepted;
        end
        while (link.in_ready !== 1'b1 && n < 400) begin
            @(negedge clk25);
            n++;
        end
        ok = (n < 400);
        @(posedge clk25);
        t_acc = $time;
        accepted++;
        @(negedge clk25);
    endtask

    task automatic wait_idle(output longint t_idle, output bit ok);
        int n;
        n = 0;
        while (link.busy !== 1'b0 && n < 2000) begin
            @(negedge clk25);
            n++;
        end
        t_idle = $time;
        ok = (n < 2000);
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (link.in_ready !== 1'b1 && n < 400) begin
            @(negedge clk25);
            n++;
        end
        ok = (n < 400);
    endtask

    task automatic test_reset();
        bit ok;
        int base, idx;
        rst = 1'b1;
        link.in_valid = 1'b0; link.in_kind = 2'b00; link.in_data = 8'h00;
        repeat (3) @(negedge clk25);
        checks++;
        if ({link.wclk, link.d0, link.dc, link.cs, link.in_ready, link.busy} !== 6'b000001)
            $display("FAIL reset_outputs: got %b expected 000001",
                     {link.wclk, link.d0, link.dc, link.cs, link.in_ready, link.busy});
        else passed++;
        base = act_q.size();
        exp_q.delete();
        rst = 1'b0;
        wait_ready(ok);
        checks++;
        if (!ok) $display("FAIL sync_ready_timeout: in_ready never rose");
        else passed++;
        checks++;
        if (act_q.size() - base != 14 || link.wclk !== 1'b0)
            $display("FAIL sync_ready_point: pulses %0d wclk %b, expected 14 pulses wclk 0",
                     act_q.size() - base, link.wclk);
        else passed++;
        repeat (20) @(negedge clk25);
        add_frame(2'b01, 8'h00);
        add_frame(2'b01, 8'h00);
        checks++;
        if (act_q.size() - base != exp_q.size())
            $display("FAIL sync_count: got %0d pulses expected %0d", act_q.size() - base, exp_q.size());
        else passed++;
        idx = first_diff(base);
        checks++;
        if (idx >= 0)
            $display("FAIL sync_pulses: pulse %0d got %b expected %b", idx + 1, act_q[base + idx], exp_q[idx]);
        else passed++;
        checks++;
        if (rx_addr != 0 || link.busy !== 1'b0)
            $display("FAIL sync_home: addr %0d busy %b expected addr 0 busy 0", rx_addr, link.busy);
        else passed++;
    endtask

    task automatic test_char();
        bit ok, ok2;
        int base, idx, a0, w0;
        longint t_acc, t_idle;
        base = act_q.size(); a0 = rx_addr; w0 = rx_writes;
        exp_q.delete();
        send(KIND_CHAR, 8'h41, t_acc, ok);
        link.in_valid = 1'b0;
        checks++;
        if ({link.wclk, link.cs, link.dc, link.d0} !== 4'b0000)
            $display("FAIL char_before_load: got %b expected 0000", {link.wclk, link.cs, link.dc, link.d0});
        else passed++;
        @(negedge clk25);
        checks++;
        if ({link.wclk, link.cs, link.dc, link.d0} !== 4'b0111)
            $display("FAIL char_bit0: got %b expected 0111", {link.wclk, link.cs, link.dc, link.d0});
        else passed++;
        wait_idle(t_idle, ok2);
        checks++;
        if (!ok || !ok2) $display("FAIL char_timeout: send %b idle %b expected 1 1", ok, ok2);
        else passed++;
        add_frame(KIND_CHAR, 8'h41);
        idx = first_diff(base);
        checks++;
        if (act_q.size() - base != exp_q.size() || idx >= 0)
            $display("FAIL char_pulses: count %0d first bad %0d expected count %0d", act_q.size() - base, idx, exp_q.size());
        else passed++;
        checks++;
        if (act_q.size() - base < 9 || rise_t[base] - t_acc != longint'((1 + CLK_DIV) * PER))
            $display("FAIL char_latency: got %0d expected %0d", (act_q.size() > base) ? rise_t[base] - t_acc : -1,
                     (1 + CLK_DIV) * PER);
        else passed++;
        checks++;
        if (t_idle - t_acc != longint'((1 + 18 * CLK_DIV) * PER + PER / 2))
            $display("FAIL char_span: got %0d expected %0d", t_idle - t_acc, (1 + 18 * CLK_DIV) * PER + PER / 2);
        else passed++;
        checks++;
        if (rx_mem[a0] !== 8'h41 || rx_writes != w0 + 1 || rx_addr != a0 + 1)
            $display("FAIL char_rx: got %h writes %0d expected 41 writes %0d", rx_mem[a0], rx_writes, w0 + 1);
        else passed++;
    endtask

    task automatic test_row();
        bit ok, ok2;
        int base, idx;
        longint t_acc, t_idle;
        base = act_q.size();
        exp_q.delete();
        send(KIND_ROW, 8'hDD, t_acc, ok);
        link.in_valid = 1'b0;
        wait_idle(t_idle, ok2);
        add_frame(KIND_ROW, 8'hDD);
        idx = first_diff(base);
        checks++;
        if (!ok || !ok2 || act_q.size() - base != exp_q.size() || idx >= 0)
            $display("FAIL row_pulses: count %0d first bad %0d expected count %0d", act_q.size() - base, idx, exp_q.size());
        else passed++;
        checks++;
        if (rx_addr != 2320) $display("FAIL row_addr: got %0d expected 2320", rx_addr);
        else passed++;
    endtask

    task automatic test_colour();
        bit ok, ok2;
        int base, idx, w0;
        longint t_acc, t_idle;
        base = act_q.size(); w0 = rx_writes;
        exp_q.delete();
        send(KIND_COLOUR, 8'h47, t_acc, ok);
        link.in_valid = 1'b0;
        wait_idle(t_idle, ok2);
        add_frame(KIND_COLOUR, 8'h47);
        idx = first_diff(base);
        checks++;
        if (!ok || !ok2 || act_q.size() - base != exp_q.size() || idx >= 0)
            $display("FAIL colour_pulses: count %0d first bad %0d expected count %0d", act_q.size() - base, idx, exp_q.size());
        else passed++;
        checks++;
        if (rx_colour !== 6'b000111 || rx_writes != w0)
            $display("FAIL colour_rx: colour %b writes %0d expected 000111 writes %0d", rx_colour, rx_writes, w0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] kinds [7];
        logic [7:0] datas [7];
        bit ok, ok2, all_ok;
        int base, idx, a0, bad;
        longint t_acc, t_idle;
        kinds = '{KIND_CHAR, KIND_CHAR, KIND_CHAR, KIND_RSVD, KIND_CHAR, KIND_CHAR, KIND_CHAR};
        datas = '{8'h41, 8'h42, 8'h43, 8'hFF, 8'h44, 8'h45, 8'h46};
        base = act_q.size(); a0 = rx_addr;
        exp_q.delete();
        ready_dropped = 1'b0; accepted = 0; acc_at_drop = -1; all_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(kinds[i], datas[i], t_acc, ok);
            all_ok &= ok;
            add_frame(kinds[i], datas[i]);
        end
        link.in_valid = 1'b0;
        wait_idle(t_idle, ok2);
        checks++;
        if (!all_ok || !ok2) $display("FAIL b2b_timeout: send %b idle %b expected 1 1", all_ok, ok2);
        else passed++;
        checks++;
        if (!ready_dropped || acc_at_drop != DEPTH + 2)
            $display("FAIL b2b_ready_drop: dropped %b after %0d accepts expected after %0d", ready_dropped, acc_at_drop, DEPTH + 2);
        else passed++;
        idx = first_diff(base);
        checks++;
        if (act_q.size() - base != 54 || exp_q.size() != 54 || idx >= 0)
            $display("FAIL b2b_pulses: count %0d first bad %0d expected count 54", act_q.size() - base, idx);
        else passed++;
        bad = 0;
        for (int i = base + 1; i < act_q.size(); i++)
            if (rise_t[i] - rise_t[i - 1] != longint'(2 * CLK_DIV * PER)) bad++;
        checks++;
        if (bad != 0) $display("FAIL b2b_gaps: %0d irregular pulse spacings expected 0", bad);
        else passed++;
        bad = 0;
        for (int i = 0; i < 6; i++)
            if (rx_mem[a0 + i] !== 8'(8'h41 + i)) bad++;
        checks++;
        if (bad != 0 || rx_addr != a0 + 6) $display("FAIL b2b_rx: %0d wrong bytes addr %0d expected 0 wrong addr %0d", bad, rx_addr, a0 + 6);
        else passed++;
    endtask

    task automatic test_random();
        bit ok, ok2, all_ok;
        int base, idx;
        logic [1:0] k;
        logic [7:0] d;
        longint t_acc, t_idle;
        base = act_q.size();
        exp_q.delete();
        all_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            k = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            send(k, d, t_acc, ok);
            all_ok &= ok;
            add_frame(k, d);
            if ($urandom_range(0, 1) == 1) begin
                link.in_valid = 1'b0;
                repeat ($urandom_range(1, 40)) @(negedge clk25);
            end
        end
        link.in_valid = 1'b0;
        wait_idle(t_idle, ok2);
        idx = first_diff(base);
        checks++;
        if (!all_ok || !ok2 || act_q.size() - base != exp_q.size() || idx >= 0)
            $display("FAIL random_pulses: count %0d first bad %0d expected count %0d", act_q.size() - base, idx, exp_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok, ok2, ok3;
        int base, idx, n;
        longint t_acc, t_idle;
        base = act_q.size();
        send(KIND_CHAR, 8'h55, t_acc, ok);
        send(KIND_CHAR, 8'h66, t_acc, ok2);
        link.in_valid = 1'b0;
        n = 0;
        while (act_q.size() - base < 4 && n < 200) begin
            @(negedge clk25);
            n++;
        end
        checks++;
        if (!ok || !ok2 || n >= 200 || link.wclk !== 1'b1)
            $display("FAIL midrst_setup: pulses %0d wclk %b expected 4 pulses wclk 1", act_q.size() - base, link.wclk);
        else passed++;
        rst = 1'b1;
        @(negedge clk25);
        rst = 1'b0;
        checks++;
        if ({link.wclk, link.d0, link.dc, link.cs, link.in_ready, link.busy} !== 6'b000001 || act_q.size() - base != 4)
            $display("FAIL midrst_abort: lines %b pulses %0d expected 000001 and 4 pulses",
                     {link.wclk, link.d0, link.dc, link.cs, link.in_ready, link.busy}, act_q.size() - base);
        else passed++;
        base = act_q.size();
        exp_q.delete();
        add_frame(2'b01, 8'h00);
        add_frame(2'b01, 8'h00);
        wait_ready(ok);
        repeat (30) @(negedge clk25);
        idx = first_diff(base);
        checks++;
        if (!ok || act_q.size() - base != 14 || idx >= 0 || link.busy !== 1'b0)
            $display("FAIL midrst_resync: pulses %0d first bad %0d busy %b expected 14 pulses busy 0",
                     act_q.size() - base, idx, link.busy);
        else passed++;
        send(KIND_CHAR, 8'h42, t_acc, ok);
        link.in_valid = 1'b0;
        wait_idle(t_idle, ok3);
        checks++;
        if (!ok || !ok3 || rx_mem[0] !== 8'h42 || rx_addr != 1)
            $display("FAIL midrst_char: got %h addr %0d expected 42 addr 1", rx_mem[0], rx_addr);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_char();
        test_row();
        test_colour();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "time limit");
    end

endmodule
